// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one word per valid/ready handshake and
// serialises it as start bit, DATA_BITS payload bits (LSB first) and
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clock cycles.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_next;
  logic                 done_next;
  logic                 baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  // Next-state, counter, shifter and line-level decode for the frame FSM.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    done_next  = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        // The word is sampled only here; tx_data is ignored at all other times.
        if (tx_valid) begin
          state_next = START;
          shift_next = tx_data;
          baud_next  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        // The bit counter doubles as the stop-bit index while in STOP.
        if (baud_end) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            state_next = IDLE;
            bit_next   = '0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state so tx can be a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
      tx_done   <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with CLKS_PER_BIT=4, 8 data bits, 1 stop bit.
module tb_uart_tx_ctrl;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks;
  int failures;

  logic [7:0] exp_q[$];
  int         done_cnt;
  int         cyc;
  int         last_start;
  int         prev_start;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer a word and hold tx_valid until the DUT is ready; push it on acceptance.
  task automatic send(input logic [7:0] d, input bit keep, output logic done_at_acc);
    bit acc;
    acc         = 1'b0;
    done_at_acc = 1'b0;
    tx_valid    = 1'b1;
    tx_data     = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clock);
      if (tx_ready) begin
        acc         = 1'b1;
        done_at_acc = tx_done;
        exp_q.push_back(d);
      end else begin
        @(posedge clock);
        #1;
      end
    end
    if (!acc) chk("send_timeout", {31'd0, tx_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Line monitor: pops the expected word at each start bit and checks every cycle.
  initial begin
    bit         active;
    bit         done_pend;
    int         mcnt;
    logic [9:0] frame;
    logic [7:0] d;
    active     = 1'b0;
    done_pend  = 1'b0;
    mcnt       = 0;
    frame      = '1;
    done_cnt   = 0;
    cyc        = 0;
    last_start = 0;
    prev_start = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (tx_done) done_cnt++;
      if (reset) begin
        active    = 1'b0;
        done_pend = 1'b0;
      end else begin
        chk("tx_done_timing", {31'd0, tx_done}, {31'd0, done_pend});
        done_pend = 1'b0;
        if (active) begin
          chk("tx_bit", {31'd0, tx}, {31'd0, frame[mcnt/CPB]});
          chk("busy_in_frame", {31'd0, tx_busy}, 32'd1);
          if (mcnt == FRAME - 1) begin
            active    = 1'b0;
            done_pend = 1'b1;
          end else begin
            mcnt++;
          end
        end else if (tx == 1'b0) begin
          chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          d          = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          frame      = {1'b1, d, 1'b0};
          prev_start = last_start;
          last_start = cyc;
          active     = 1'b1;
          mcnt       = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc_done;
    int   t0;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_cycles(2);
    @(negedge clock);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_cycles(3);

    // Single frame 0xA5
    t0 = done_cnt;
    send(8'hA5, 1'b0, acc_done);
    wait_cycles(FRAME + 8);
    chk("single_done_cnt", done_cnt - t0, 32'd1);
    chk("single_q_empty", exp_q.size(), 32'd0);

    // Back-to-back with tx_valid held high
    t0 = done_cnt;
    send(8'h00, 1'b1, acc_done);
    send(8'hFF, 1'b0, acc_done);
    chk("b2b_done_with_ready", {31'd0, acc_done}, 32'd1);
    wait_cycles(FRAME + 8);
    chk("b2b_start_spacing", last_start - prev_start, FRAME + 1);
    chk("b2b_done_cnt", done_cnt - t0, 32'd2);
    chk("b2b_q_empty", exp_q.size(), 32'd0);

    // Offer while busy must be rejected
    send(8'hC3, 1'b0, acc_done);
    wait_cycles(14);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clock);
    chk("busy_ready", {31'd0, tx_ready}, 32'd0);
    chk("busy_busy", {31'd0, tx_busy}, 32'd1);
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    wait_cycles(FRAME);
    chk("busy_idle_after", {31'd0, tx_busy}, 32'd0);
    chk("busy_q_empty", exp_q.size(), 32'd0);

    // Payload stable while tx_data churns
    send(8'h81, 1'b0, acc_done);
    for (int i = 0; i < FRAME + 4; i++) begin
      tx_data = 8'($urandom);
      @(posedge clock);
      #1;
    end
    wait_cycles(4);
    chk("stable_q_empty", exp_q.size(), 32'd0);

    // Reset during the third data bit aborts without tx_done
    t0 = done_cnt;
    send(8'h5A, 1'b0, acc_done);
    wait_cycles(12);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    chk("abort_ready", {31'd0, tx_ready}, 32'd1);
    wait_cycles(FRAME + 8);
    chk("abort_no_done", done_cnt - t0, 32'd0);

    // Reset wins over a simultaneous handshake
    @(posedge clock);
    #1;
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clock);
    chk("simul_tx", {31'd0, tx}, 32'd1);
    chk("simul_busy", {31'd0, tx_busy}, 32'd0);
    wait_cycles(10);
    chk("simul_still_idle", {31'd0, tx_busy}, 32'd0);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame.
REQ-004 SHALL have port clock  input  1  rising-edge system clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tx_valid  input  1  requester offers a byte.
REQ-007 SHALL have port tx_data  input  DATA_BITS  byte to send; LSB is transmitted first.
REQ-008 SHALL have port tx_ready  output  1  controller can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line; idle high.
REQ-010 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 SHALL drive tx_ready = 1 only in IDLE (combinational from state); tx_busy = not IDLE.
REQ-014 SHALL accept a byte on the cycle tx_valid && tx_ready, capture tx_data into an internal shift register, and enter START on the next edge.
REQ-015 SHALL ignore tx_data and tx_valid changes outside the handshake cycle.
REQ-016 SHALL keep an internal baud counter 0..CLKS_PER_BIT-1, cleared on every state change, advancing each cycle in START/DATA/STOP.
REQ-017 SHALL keep an internal bit counter 0..DATA_BITS-1, cleared on entry to DATA, incremented at each bit-period end in DATA.
REQ-018 SHALL drive tx as a registered output: 0 for the whole START period.
REQ-019 SHALL drive tx to the current shift-register LSB for each DATA period and shift right at each bit-period end.
REQ-020 SHALL drive tx to 1 in STOP and IDLE.
REQ-021 SHALL use the following transitions:
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP when the bit-period end coincides with bit counter = DATA_BITS-1.
  - STOP -> IDLE after STOP_BITS*CLKS_PER_BIT cycles.
REQ-022 SHALL hold the line low for exactly CLKS_PER_BIT cycles per start bit; frame length SHALL be (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles measured from the first start-bit cycle.
REQ-023 SHALL assert tx_done for exactly one cycle, registered, on the first IDLE cycle after STOP.
REQ-024 SHALL allow a new handshake on that same first IDLE cycle (tx_done and tx_ready both 1), giving a minimum frame period of frame length + 1 cycles.
REQ-025 SHALL keep the counters from wrapping outside their ranges; baud counter terminal count is CLKS_PER_BIT-1, bit counter terminal is DATA_BITS-1.
REQ-026 SHALL keep tx_valid held high during a frame from causing a second capture until IDLE.
REQ-027 SHALL support parameter ranges CLKS_PER_BIT >= 2, DATA_BITS 5..9, STOP_BITS 1..2; other values are unsupported.

Reset
REQ-028 SHALL on reset set state IDLE, tx = 1, tx_done = 0, tx_busy = 0, both counters and the shift register to 0.
REQ-029 SHALL abort any frame in progress on reset, return tx to 1 on the next edge, and emit no tx_done for the aborted frame.
REQ-030 SHALL make reset take priority over a simultaneous handshake, which is not captured.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1)
REQ-031 SHALL check a single frame: tx_data=0xA5 with tx_valid for one cycle -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses once on the cycle after the 40th frame cycle.
REQ-032 SHALL check back-to-back frames: tx_valid held high with 0x00 then 0xFF -> second start bit begins 41 cycles after the first; tx_done and tx_ready are both 1 in the same cycle.
REQ-033 SHALL check busy rejection: tx_valid pulsed with 0x3C during the DATA state of a frame -> no capture, tx_ready = 0, and the current frame is unaltered.
REQ-034 SHALL check mid-frame reset: reset asserted in the 3rd data bit -> tx = 1, tx_busy = 0, and tx_ready = 1 next cycle, with no tx_done.
REQ-035 SHALL check data stability: tx_data changes every cycle after the handshake of 0x81 -> the transmitted payload is still 1,0,0,0,0,0,0,1.
REQ-036 SHALL check simultaneous reset and handshake: reset=1 and tx_valid=1 with 0x55 -> stays IDLE and tx remains 1.
